// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the state byte-position helper.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_NB      = 4;

  localparam logic AES_MODE_ENC = 1'b0;
  localparam logic AES_MODE_DEC = 1'b1;

  // LSB bit offset of s(row,col); byte k = row + 4*col sits at [127-8k -: 8]
  function automatic int byte_off(input int row, input int col);
    return AES_STATE_W - 8 - 8 * (row + AES_NB * col);
  endfunction

endpackage

// File: rtl/aes_shift_rows_lane.sv
// Combinational ShiftRows / InvShiftRows permutation of one 128-bit state.
module aes_shift_rows_lane
  import aes_pkg::*;
(
  input  logic                   mode,
  input  logic [AES_STATE_W-1:0] state,
  output logic [AES_STATE_W-1:0] perm
);

  always_comb begin
    perm = '0;
    for (int r = 0; r < AES_NB; r++) begin
      for (int c = 0; c < AES_NB; c++) begin
        perm[byte_off(r, c) +: 8] = state[byte_off(r,
          (mode == AES_MODE_DEC) ? ((c - r + AES_NB) % AES_NB)
                                 : ((c + r) % AES_NB)) +: 8];
      end
    end
  end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Registered multi-lane ShiftRows stage with a 2-entry skid buffer,
// tag passthrough and a saturating delivered-transfer counter.
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 1,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic [AES_STATE_W*LANES-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TAG_W-1:0]             out_tag,
  output logic [AES_STATE_W*LANES-1:0] out_data,
  input  logic                         cnt_clear,
  output logic [CNT_W-1:0]             blk_count
);

  localparam int DW = AES_STATE_W * LANES;

  logic [DW-1:0]    perm_data;
  logic             main_valid;
  logic [DW-1:0]    main_data;
  logic [TAG_W-1:0] main_tag;
  logic             skid_valid;
  logic [DW-1:0]    skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             rdy_q;
  logic             acc;
  logic             dlv;
  logic             main_free;
  logic             skid_nxt;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_shift_rows_lane u_lane (
      .mode  (in_mode),
      .state (in_data[AES_STATE_W*l +: AES_STATE_W]),
      .perm  (perm_data[AES_STATE_W*l +: AES_STATE_W])
    );
  end

  assign acc       = in_valid && rdy_q;
  assign dlv       = main_valid && out_ready;
  assign main_free = !main_valid || out_ready;

  // skid can only fill while main is stalled; it empties whenever main frees
  always_comb begin
    skid_nxt = skid_valid;
    if (main_free)
      skid_nxt = 1'b0;
    else if (acc)
      skid_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
      rdy_q      <= 1'b0;
    end else begin
      skid_valid <= skid_nxt;
      rdy_q      <= !skid_nxt;
      if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          main_tag   <= skid_tag;
        end else if (acc) begin
          main_valid <= 1'b1;
          main_data  <= perm_data;
          main_tag   <= in_tag;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (acc) begin
        skid_data <= perm_data;
        skid_tag  <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      blk_count <= '0;
    else if (cnt_clear)
      blk_count <= '0;
    else if (dlv && blk_count != {CNT_W{1'b1}})
      blk_count <= blk_count + 1'b1;
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Scoreboard bench for aes_shift_rows_pipe (2 lanes, 2-bit counter).
module tb_aes_shift_rows_pipe;

  localparam int LANES = 2;
  localparam int TAG_W = 4;
  localparam int CNT_W = 2;
  localparam int DW    = 128 * LANES;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } xfer_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [DW-1:0]    out_data;
  logic             cnt_clear;
  logic [CNT_W-1:0] blk_count;

  int    n_chk = 0;
  int    n_err = 0;
  int    n_out = 0;
  xfer_t sb[$];
  xfer_t last_out;
  xfer_t hold_q;
  logic  stall_q = 1'b0;
  logic  rnd_done;

  aes_shift_rows_pipe #(
    .LANES (LANES),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .cnt_clear (cnt_clear),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [299:0] got,
                     input logic [299:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] sr_ref(input logic [127:0] s,
                                          input logic inv);
    logic [7:0]   b[16];
    logic [127:0] o;
    int           src;
    for (int k = 0; k < 16; k++) b[k] = s[127 - 8*k -: 8];
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127 - 8*(r + 4*c) -: 8] = b[r + 4*src];
      end
    return o;
  endfunction

  function automatic logic [DW-1:0] pipe_ref(input logic [DW-1:0] d,
                                             input logic inv);
    logic [DW-1:0] o;
    for (int l = 0; l < LANES; l++)
      o[128*l +: 128] = sr_ref(d[128*l +: 128], inv);
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one transfer; called at posedge+1, returns at posedge+1 after accept
  task automatic send(input logic mode, input logic [TAG_W-1:0] tag,
                      input logic [DW-1:0] data);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_tag   = tag;
    in_data  = data;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{tag, pipe_ref(data, mode)});
        ok = 1'b1;
      end
      step();
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q)
        chk("hold", {out_valid, out_tag, out_data}, {1'b1, hold_q});
      stall_q <= out_valid && !out_ready;
      hold_q  <= '{out_tag, out_data};
      if (out_valid && out_ready) begin
        n_out++;
        last_out = '{out_tag, out_data};
        if (sb.size() == 0) chk("unexpected_out", sb.size(), 1);
        else chk("sb_data", {out_tag, out_data}, sb.pop_front());
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    chk("drain", sb.size(), 0);
  endtask

  localparam logic [127:0] V_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V_FWD = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] V_INV = 128'h000d0a0704010e0b0805020f0c090603;

  initial begin
    logic [127:0] l1;
    logic [127:0] v;
    int n0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_tag    = '0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clear = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_tag, out_data}, 0);
    chk("rst_blk_count", blk_count, 0);
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("ready_after_rst", in_ready, 1);

    // forward vector on lane0, independent state on lane1
    out_ready = 1'b1;
    l1 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    send(1'b0, 4'h1, {l1, V_IN});
    step();
    chk("fwd_lane0", last_out.data[127:0], V_FWD);
    chk("fwd_lane1", last_out.data[255:128], sr_ref(l1, 1'b0));
    chk("cnt_one", blk_count, 1);

    send(1'b1, 4'h2, {l1, V_IN});
    step();
    chk("inv_lane0", last_out.data[127:0], V_INV);

    send(1'b1, 4'h3, {sr_ref(l1, 1'b0), V_FWD});
    step();
    chk("roundtrip", last_out.data, {l1, V_IN});

    // back-pressure: two fill main+skid, third stalls
    out_ready = 1'b0;
    n0 = n_out;
    send(1'b0, 4'ha, {l1, V_IN});
    send(1'b1, 4'hb, {V_IN, l1});
    chk("bp_ready_low", in_ready, 0);
    fork
      send(1'b0, 4'hc, {V_FWD, V_INV});
      begin
        repeat (3) step();
        chk("bp_still_low", in_ready, 0);
        chk("bp_head_tag", out_tag, 4'ha);
        out_ready = 1'b1;
      end
    join
    drain();
    repeat (2) step();
    chk("bp_count", n_out - n0, 3);
    chk("bp_idle", out_valid, 0);

    // randomized stream with random back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          v = {$urandom, $urandom, $urandom, $urandom};
          send(1'($urandom), 4'($urandom), {v, ~v ^ 128'($urandom)});
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(0, 2) != 0);
          step();
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // counter saturation and clear priority
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("cnt_clear", blk_count, 0);
    for (int i = 0; i < 5; i++) send(1'b0, 4'(i), {V_IN, l1});
    repeat (2) step();
    chk("cnt_sat", blk_count, 3);
    n0 = n_out;
    send(1'b0, 4'h7, {l1, V_IN});
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_with_hs", blk_count, 0);
    chk("clr_hs_done", n_out - n0, 1);

    // async reset with both buffers full
    out_ready = 1'b0;
    send(1'b0, 4'h5, {l1, V_IN});
    send(1'b0, 4'h6, {V_IN, l1});
    chk("full_ready_low", in_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    sb.delete();
    n0 = n_out;
    in_valid = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_cnt", blk_count, 0);
    chk("post_rst_outs", n_out - n0, 0);
    send(1'b1, 4'h9, {V_IN, V_IN});
    step();
    chk("post_rst_xfer", last_out.data, {V_INV, V_INV});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
